// File: rtl/multicycle_ctrl.sv
// Multicycle control sequencer: walks each instruction through FETCH/DECODE/EXEC/MEM/WB,
// drives datapath enables and memory handshakes, and halts in FAULT on illegal opcodes or memory timeouts.
module multicycle_ctrl #(
  parameter int unsigned IMEM_WAIT_MAX = 15,
  parameter int unsigned DMEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        funcout,
  input  logic        imem_rdy,
  input  logic        dmem_rdy,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        memwrite,
  output logic        ir_en,
  output logic        src1reg_en,
  output logic        src2reg_en,
  output logic        alusrcb,
  output logic [2:0]  alucontrol,
  output logic        regwrite,
  output logic        alures2reg,
  output logic        memory2reg,
  output logic        jal,
  output logic        pc_en,
  output logic [1:0]  pc_src,
  output logic        fault,
  output logic        fault_cause
);

  localparam int unsigned IMEM_CNT_W = $clog2(IMEM_WAIT_MAX + 1);
  localparam int unsigned DMEM_CNT_W = $clog2(DMEM_WAIT_MAX + 1);
  localparam int unsigned CNT_W_RAW  = (IMEM_CNT_W > DMEM_CNT_W) ? IMEM_CNT_W : DMEM_CNT_W;
  localparam int unsigned CNT_W      = (CNT_W_RAW == 0) ? 1 : CNT_W_RAW;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_FAULT
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cause_q, cause_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic       is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr, legal;
  logic       unused_instr_bits;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7_b5 = instr[30];
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  assign is_r      = (opcode == OP_R);
  assign is_i      = (opcode == OP_I);
  assign is_load   = (opcode == OP_LOAD)   && (funct3 == 3'b010);
  assign is_store  = (opcode == OP_STORE)  && (funct3 == 3'b010);
  assign is_branch = (opcode == OP_BRANCH) && (funct3[2:1] == 2'b00);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign legal     = is_r | is_i | is_load | is_store | is_branch | is_jal | is_jalr;

  // funct3 -> ALU op; sltu shares the slt encoding, sra shares srl
  function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub);
    logic [2:0] op;
    unique case (f3)
      3'b000:  op = sub ? ALU_SUB : ALU_ADD;
      3'b001:  op = 3'b110;
      3'b010:  op = 3'b101;
      3'b011:  op = 3'b101;
      3'b100:  op = 3'b100;
      3'b101:  op = 3'b111;
      3'b110:  op = 3'b011;
      default: op = 3'b010;
    endcase
    return op;
  endfunction

  // State, wait counter and latched fault cause
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      cause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  // Next state and combinational outputs; everything held at 0 while reset is low
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cause_d     = cause_q;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    memwrite    = 1'b0;
    ir_en       = 1'b0;
    src1reg_en  = 1'b0;
    src2reg_en  = 1'b0;
    alusrcb     = 1'b0;
    alucontrol  = ALU_ADD;
    regwrite    = 1'b0;
    alures2reg  = 1'b0;
    memory2reg  = 1'b0;
    jal         = 1'b0;
    pc_en       = 1'b0;
    pc_src      = 2'b00;
    fault       = 1'b0;
    fault_cause = 1'b0;

    if (reset) begin
      unique case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_rdy) begin
            ir_en   = 1'b1;
            cnt_d   = '0;
            state_d = S_DECODE;
          end else if (cnt_q == CNT_W'(IMEM_WAIT_MAX)) begin
            cnt_d   = '0;
            cause_d = 1'b1;
            state_d = S_FAULT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_DECODE: begin
          src1reg_en = 1'b1;
          src2reg_en = 1'b1;
          if (legal) begin
            state_d = S_EXEC;
          end else begin
            cause_d = 1'b0;
            state_d = S_FAULT;
          end
        end

        S_EXEC: begin
          if (is_r || is_i) begin
            alucontrol = alu_decode(funct3, is_r && funct7_b5);
            alusrcb    = is_i;
            state_d    = S_WB;
          end else if (is_load || is_store) begin
            alucontrol = ALU_ADD;
            alusrcb    = 1'b1;
            state_d    = S_MEM;
          end else if (is_branch) begin
            alucontrol = ALU_SUB;
            pc_en      = 1'b1;
            pc_src     = (funcout ^ funct3[0]) ? 2'b01 : 2'b00;
            state_d    = S_FETCH;
          end else begin
            alucontrol = ALU_ADD;
            alusrcb    = 1'b1;
            state_d    = S_WB;
          end
        end

        S_MEM: begin
          dmem_req = 1'b1;
          memwrite = is_store;
          if (dmem_rdy) begin
            cnt_d = '0;
            if (is_store) begin
              pc_en   = 1'b1;
              pc_src  = 2'b00;
              state_d = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end else if (cnt_q == CNT_W'(DMEM_WAIT_MAX)) begin
            cnt_d   = '0;
            cause_d = 1'b1;
            state_d = S_FAULT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_WB: begin
          regwrite = 1'b1;
          pc_en    = 1'b1;
          if (is_jal) begin
            jal    = 1'b1;
            pc_src = 2'b01;
          end else if (is_jalr) begin
            jal    = 1'b1;
            pc_src = 2'b10;
          end else if (is_load) begin
            memory2reg = 1'b1;
          end else begin
            alures2reg = 1'b1;
          end
          state_d = S_FETCH;
        end

        S_FAULT: begin
          fault       = 1'b1;
          fault_cause = cause_q;
        end

        default: begin
          cnt_d   = '0;
          state_d = S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: a per-instruction trace model predicts every cycle's outputs.
module tb_multicycle_ctrl;

  localparam int unsigned IMAX = 15;
  localparam int unsigned DMAX = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        funcout = 1'b0;
  logic        imem_rdy = 1'b0;
  logic        dmem_rdy = 1'b0;
  logic        imem_req, dmem_req, memwrite, ir_en, src1reg_en, src2reg_en, alusrcb;
  logic [2:0]  alucontrol;
  logic        regwrite, alures2reg, memory2reg, jal, pc_en;
  logic [1:0]  pc_src;
  logic        fault, fault_cause;

  multicycle_ctrl #(.IMEM_WAIT_MAX(IMAX), .DMEM_WAIT_MAX(DMAX)) dut (
    .clk(clk), .reset(reset), .instr(instr), .funcout(funcout),
    .imem_rdy(imem_rdy), .dmem_rdy(dmem_rdy),
    .imem_req(imem_req), .dmem_req(dmem_req), .memwrite(memwrite), .ir_en(ir_en),
    .src1reg_en(src1reg_en), .src2reg_en(src2reg_en), .alusrcb(alusrcb),
    .alucontrol(alucontrol), .regwrite(regwrite), .alures2reg(alures2reg),
    .memory2reg(memory2reg), .jal(jal), .pc_en(pc_en), .pc_src(pc_src),
    .fault(fault), .fault_cause(fault_cause)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       imem_req, dmem_req, memwrite, ir_en, src1reg_en, src2reg_en, alusrcb;
    logic [2:0] alucontrol;
    logic       regwrite, alures2reg, memory2reg, jal, pc_en;
    logic [1:0] pc_src;
    logic       fault, fault_cause;
  } outs_t;

  outs_t exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;
  int    pc_en_seen = 0;
  int    dmem_req_seen = 0;

  // ALU op per funct3 for R/I instructions (index = funct3)
  logic [2:0] alu_tbl [8] = '{3'b000, 3'b110, 3'b101, 3'b101, 3'b100, 3'b111, 3'b011, 3'b010};

  // Compare DUT outputs against the expected trace every cycle one is queued
  always @(negedge clk) begin
    outs_t a, e;
    string t;
    a = {imem_req, dmem_req, memwrite, ir_en, src1reg_en, src2reg_en, alusrcb, alucontrol,
         regwrite, alures2reg, memory2reg, jal, pc_en, pc_src, fault, fault_cause};
    if (pc_en) pc_en_seen++;
    if (dmem_req) dmem_req_seen++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got %b expected %b", t, a, e);
      end
    end
  end

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  task automatic step(input logic ir, input logic dr, input outs_t e, input string t);
    imem_rdy = ir;
    dmem_rdy = dr;
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string nm);
    reset = 1'b0;
    step(1'b0, 1'b0, '0, {nm, " reset"});
    step(1'b1, 1'b1, '0, {nm, " reset hold"});
    reset = 1'b1;
  endtask

  task automatic fault_cycles(input logic cause, input string nm);
    outs_t e;
    e = '0;
    e.fault = 1'b1;
    e.fault_cause = cause;
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, e, {nm, " fault"});
    do_reset(nm);
  endtask

  // Expected trace of one instruction given fetch/mem wait counts; rst_mem >= 0 resets in that MEM cycle
  task automatic run_instr(input logic [31:0] iw, input int iwait, input int dwait,
                           input logic fo, input int rst_mem, input string nm, output int ncyc);
    logic [6:0] op;
    logic [2:0] f3;
    logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr;
    outs_t e;
    op = iw[6:0];
    f3 = iw[14:12];
    is_r    = (op == 7'h33);
    is_i    = (op == 7'h13);
    is_ld   = (op == 7'h03) && (f3 == 3'd2);
    is_st   = (op == 7'h23) && (f3 == 3'd2);
    is_br   = (op == 7'h63) && (f3 < 3'd2);
    is_jal  = (op == 7'h6F);
    is_jalr = (op == 7'h67);
    instr = iw;
    funcout = fo;
    ncyc = 0;
    pc_en_seen = 0;
    dmem_req_seen = 0;

    for (int w = 0; w < iwait && w <= int'(IMAX); w++) begin
      e = '0; e.imem_req = 1'b1;
      step(1'b0, 1'b1, e, {nm, " fetch-wait"});
      ncyc++;
    end
    if (iwait > int'(IMAX)) begin
      fault_cycles(1'b1, nm);
      return;
    end
    e = '0; e.imem_req = 1'b1; e.ir_en = 1'b1;
    step(1'b1, 1'b1, e, {nm, " fetch"});
    ncyc++;

    e = '0; e.src1reg_en = 1'b1; e.src2reg_en = 1'b1;
    step(1'b1, 1'b1, e, {nm, " decode"});
    ncyc++;
    if (!(is_r || is_i || is_ld || is_st || is_br || is_jal || is_jalr)) begin
      fault_cycles(1'b0, nm);
      return;
    end

    e = '0;
    if (is_r) e.alucontrol = (f3 == 3'd0 && iw[30]) ? 3'b001 : alu_tbl[f3];
    else if (is_i) begin e.alucontrol = alu_tbl[f3]; e.alusrcb = 1'b1; end
    else if (is_br) begin
      e.alucontrol = 3'b001;
      e.pc_en = 1'b1;
      e.pc_src = (fo != f3[0]) ? 2'b01 : 2'b00;
    end else e.alusrcb = 1'b1;
    step(1'b1, 1'b1, e, {nm, " exec"});
    ncyc++;
    if (is_br) return;

    if (is_ld || is_st) begin
      for (int w = 0; ; w++) begin
        if (w > int'(DMAX)) begin
          fault_cycles(1'b1, nm);
          return;
        end
        if (w == rst_mem) begin
          do_reset(nm);
          return;
        end
        e = '0; e.dmem_req = 1'b1; e.memwrite = is_st;
        if (w == dwait) begin
          e.pc_en = is_st;
          step(1'b1, 1'b1, e, {nm, " mem-done"});
          ncyc++;
          break;
        end
        step(1'b1, 1'b0, e, {nm, " mem-wait"});
        ncyc++;
      end
      if (is_st) return;
    end

    e = '0; e.regwrite = 1'b1; e.pc_en = 1'b1;
    if (is_jal) begin e.jal = 1'b1; e.pc_src = 2'b01; end
    else if (is_jalr) begin e.jal = 1'b1; e.pc_src = 2'b10; end
    else if (is_ld) e.memory2reg = 1'b1;
    else e.alures2reg = 1'b1;
    step(1'b1, 1'b1, e, {nm, " wb"});
    ncyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    @(posedge clk);
    #1;
    do_reset("init");

    run_instr(32'h002081B3, 0, 0, 1'b0, -1, "add", n);
    chk("add cpi", n, 4);
    chk("add pc_en pulses", pc_en_seen, 1);
    run_instr(32'h402081B3, 0, 0, 1'b0, -1, "sub", n);
    run_instr(32'h00508093, 0, 0, 1'b0, -1, "addi", n);
    run_instr(32'h0020F1B3, 0, 0, 1'b0, -1, "and", n);
    run_instr(32'h0020A1B3, 0, 0, 1'b0, -1, "slt", n);
    run_instr(32'h0040C093, 0, 0, 1'b0, -1, "xori", n);
    run_instr(32'h4010D093, 0, 0, 1'b0, -1, "srai", n);

    run_instr(32'h0000A283, 0, 3, 1'b0, -1, "lw", n);
    chk("lw total cycles", n, 8);
    chk("lw dmem_req cycles", dmem_req_seen, 4);
    chk("lw pc_en pulses", pc_en_seen, 1);
    run_instr(32'h0050A023, 0, 0, 1'b0, -1, "sw", n);
    chk("sw cpi", n, 4);
    chk("sw pc_en pulses", pc_en_seen, 1);

    run_instr(32'h00208463, 0, 0, 1'b1, -1, "beq taken", n);
    chk("beq cpi", n, 3);
    run_instr(32'h00208463, 0, 0, 1'b0, -1, "beq not-taken", n);
    chk("beq nt pc_en pulses", pc_en_seen, 1);
    run_instr(32'h00209463, 0, 0, 1'b0, -1, "bne taken", n);
    run_instr(32'h008000EF, 0, 0, 1'b0, -1, "jal", n);
    chk("jal cpi", n, 4);
    run_instr(32'h000080E7, 2, 0, 1'b0, -1, "jalr", n);

    run_instr(32'h002081B3, 15, 0, 1'b0, -1, "imem rdy at max", n);
    chk("imem rdy at max cycles", n, 19);
    run_instr(32'h0000A283, 0, 15, 1'b0, -1, "dmem rdy at max", n);
    chk("dmem rdy at max cycles", n, 20);

    run_instr(32'h0000007F, 0, 0, 1'b0, -1, "illegal", n);
    run_instr(32'h00008283, 1, 0, 1'b0, -1, "lb illegal", n);
    run_instr(32'h002081B3, 16, 0, 1'b0, -1, "imem timeout", n);
    run_instr(32'h0000A283, 0, 16, 1'b0, -1, "dmem timeout", n);

    run_instr(32'h0000A283, 0, 5, 1'b0, 2, "reset in mem", n);
    chk("reset in mem pc_en", pc_en_seen, 0);
    run_instr(32'h002081B3, 15, 0, 1'b0, -1, "after reset", n);

    chk("expectations drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
